// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer: pattern modes, FSM states, bounce direction.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ROL    = 2'b00,
        MODE_ROR    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

endpackage

// File: rtl/led_seq_timer.sv
// Step prescaler: counts while enabled and flags the cycle in which a pattern step is due.
module led_seq_timer #(
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    output logic             step
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;

    // Compare with >= so a period shrunk below cnt fires at once instead of wrapping.
    always_comb begin
        last = (period == '0) ? '0 : period - ONE;
        step = enable && (cnt >= last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= step ? '0 : cnt + ONE;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer top: run/pause FSM and pattern generator (rotate, bounce, fill).
// Define LED_SEQ_BUTTON_SYNC_EN to treat start/stop as raw buttons (synchronised, edge-detected).
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LED = 8,
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] period,
    output logic [N_LED-1:0] led,
    output logic             running,
    output logic             step
);

    localparam logic [N_LED-1:0] LED_INIT = N_LED'(1);

    logic   start_req;
    logic   stop_req;
    state_t state;
    mode_t  mode_q;
    mode_t  mode_in;
    dir_t   dir;
    dir_t   next_dir;
    logic   [N_LED-1:0] next_led;
    logic   [N_LED-1:0] shifted;
    logic   enable;
    logic   tick;

`ifdef LED_SEQ_BUTTON_SYNC_EN
    logic [2:0] start_sync;
    logic [2:0] stop_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_sync <= '0;
            stop_sync  <= '0;
        end else begin
            start_sync <= {start_sync[1:0], start};
            stop_sync  <= {stop_sync[1:0], stop};
        end
    end

    assign start_req = start_sync[1] & ~start_sync[2];
    assign stop_req  = stop_sync[1] & ~stop_sync[2];
`else
    assign start_req = start;
    assign stop_req  = stop;
`endif

    assign mode_in = mode_t'(mode);
    // Gating with stop freezes the prescaler in the very cycle the pause is requested.
    assign enable  = (state == ST_RUN) && !stop_req;

    led_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .period (period),
        .step   (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            running <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req && !stop_req) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop_req) begin
                        state   <= ST_PAUSED;
                        running <= 1'b0;
                    end
                end
                ST_PAUSED: begin
                    if (start_req && !stop_req) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        next_led = led;
        next_dir = dir;
        shifted  = '0;
        case (mode_q)
            MODE_ROL:  next_led = {led[N_LED-2:0], led[N_LED-1]};
            MODE_ROR:  next_led = {led[0], led[N_LED-1:1]};
            MODE_BOUNCE: begin
                if (dir == DIR_LEFT) begin
                    shifted  = led << 1;
                    next_dir = shifted[N_LED-1] ? DIR_RIGHT : DIR_LEFT;
                end else begin
                    shifted  = led >> 1;
                    next_dir = shifted[0] ? DIR_LEFT : DIR_RIGHT;
                end
                next_led = shifted;
                if (shifted == '0) begin
                    next_led = LED_INIT;
                    next_dir = DIR_LEFT;
                end
            end
            MODE_FILL: next_led = (&led) ? LED_INIT : {led[N_LED-2:0], 1'b1};
            default:   next_led = LED_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led    <= LED_INIT;
            dir    <= DIR_LEFT;
            mode_q <= MODE_ROL;
            step   <= 1'b0;
        end else begin
            step <= tick;
            if (tick) begin
                mode_q <= mode_in;
                if (mode_in != mode_q) begin
                    led <= LED_INIT;
                    dir <= DIR_LEFT;
                end else begin
                    led <= next_led;
                    dir <= next_dir;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer (N_LED=8); step-by-step scoreboard plus vector table.
module tb_led_pattern_sequencer;

    localparam int N  = 8;
    localparam int CW = 27;

    typedef struct {
        logic [1:0]    mode;
        logic [CW-1:0] period;
        logic [N-1:0]  exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [1:0]    mode;
    logic [CW-1:0] period;
    logic [N-1:0]  led;
    logic          running;
    logic          step;

    int           chk_cnt  = 0;
    int           pass_cnt = 0;
    logic [N-1:0] exp_q[$];
    vec_t         vecs[$];

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .N_LED (N),
        .CNT_W (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .period  (period),
        .led     (led),
        .running (running),
        .step    (step)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Every step pulse must match the next queued expectation.
    always @(posedge clk) begin
        #1;
        if (step === 1'b1) begin
            if (exp_q.size() == 0) check("step_expected", 32'(exp_q.size()), 32'd1);
            else check("step_led", 32'(led), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_steps(output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 300) begin
            @(posedge clk);
            #2;
            cycles++;
        end
        if (exp_q.size() != 0) begin
            check("step_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic add_vec(input logic [1:0] m, input logic [CW-1:0] p, input logic [N-1:0] e);
        vec_t v;
        v.mode   = m;
        v.period = p;
        v.exp    = e;
        vecs.push_back(v);
    endtask

    initial begin
        int           c;
        logic [N-1:0] e;

        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; period = CW'(4);
        #12;
        check("reset_led", 32'(led), 32'h01);
        check("reset_running", 32'(running), 32'd0);
        check("reset_step", 32'(step), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        tick_n(3);
        check("idle_running", 32'(running), 32'd0);

`ifdef LED_SEQ_BUTTON_SYNC_EN
        period = CW'(1000);
        start  = 1'b1;
        tick_n(2);
        check("sync_start_early", 32'(running), 32'd0);
        tick_n(1);
        check("sync_start_latency", 32'(running), 32'd1);
        tick_n(17);
        start = 1'b0;
        tick_n(5);
        check("sync_start_held", 32'(running), 32'd1);
        stop = 1'b1;
        tick_n(3);
        check("sync_stop", 32'(running), 32'd0);
        tick_n(10);
        stop = 1'b0;
        tick_n(5);
        check("sync_no_retrigger", 32'(running), 32'd0);
`else
        // Rotate-left, period 4: first step 4 cycles after the start edge.
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
        check("rot_running", 32'(running), 32'd1);
        e = 8'h01;
        for (int i = 0; i < 9; i++) begin
            e = {e[N-2:0], e[N-1]};
            exp_q.push_back(e);
            wait_steps(c);
            check("rot_interval", 32'(c), 32'd4);
        end

        // Bounce, fill, mode switches and period 0/2 from a vector table.
        add_vec(2'b10, CW'(1), 8'h01);
        add_vec(2'b10, CW'(1), 8'h02); add_vec(2'b10, CW'(1), 8'h04);
        add_vec(2'b10, CW'(1), 8'h08); add_vec(2'b10, CW'(1), 8'h10);
        add_vec(2'b10, CW'(1), 8'h20); add_vec(2'b10, CW'(1), 8'h40);
        add_vec(2'b10, CW'(1), 8'h80); add_vec(2'b10, CW'(1), 8'h40);
        add_vec(2'b10, CW'(1), 8'h20); add_vec(2'b10, CW'(1), 8'h10);
        add_vec(2'b10, CW'(1), 8'h08); add_vec(2'b10, CW'(1), 8'h04);
        add_vec(2'b10, CW'(1), 8'h02); add_vec(2'b10, CW'(1), 8'h01);
        add_vec(2'b10, CW'(1), 8'h02);
        add_vec(2'b11, CW'(1), 8'h01); add_vec(2'b11, CW'(1), 8'h03);
        add_vec(2'b11, CW'(1), 8'h07); add_vec(2'b11, CW'(1), 8'h0F);
        add_vec(2'b11, CW'(1), 8'h1F); add_vec(2'b11, CW'(1), 8'h3F);
        add_vec(2'b11, CW'(1), 8'h7F); add_vec(2'b11, CW'(1), 8'hFF);
        add_vec(2'b11, CW'(1), 8'h01); add_vec(2'b11, CW'(1), 8'h03);
        add_vec(2'b00, CW'(1), 8'h01); add_vec(2'b00, CW'(1), 8'h02);
        add_vec(2'b01, CW'(0), 8'h01); add_vec(2'b01, CW'(0), 8'h80);
        add_vec(2'b01, CW'(0), 8'h40); add_vec(2'b01, CW'(2), 8'h20);
        foreach (vecs[i]) begin
            mode   = vecs[i].mode;
            period = vecs[i].period;
            exp_q.push_back(vecs[i].exp);
            wait_steps(c);
        end

        // Pause at cnt=2 with period 4, then resume: step 2 cycles after start.
        period = CW'(4);
        exp_q.push_back(8'h10);
        wait_steps(c);
        check("pause_pre_interval", 32'(c), 32'd4);
        tick_n(2);
        stop = 1'b1;
        tick_n(1);
        stop = 1'b0;
        check("pause_running", 32'(running), 32'd0);
        tick_n(6);
        check("pause_led_frozen", 32'(led), 32'h10);
        check("pause_still", 32'(running), 32'd0);
        start = 1'b1;
        exp_q.push_back(8'h08);
        tick_n(1);
        start = 1'b0;
        check("resume_running", 32'(running), 32'd1);
        wait_steps(c);
        check("resume_latency", 32'(c), 32'd2);
        start = 1'b1;
        stop  = 1'b1;
        tick_n(1);
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_pauses", 32'(running), 32'd0);
        tick_n(3);
        check("start_stop_led", 32'(led), 32'h08);

        // Period shrink mid-count, then asynchronous reset while running.
        rst = 1'b1;
        tick_n(1);
        rst    = 1'b0;
        mode   = 2'b00;
        period = CW'(100);
        start  = 1'b1;
        tick_n(1);
        start = 1'b0;
        tick_n(50);
        period = CW'(3);
        exp_q.push_back(8'h02);
        wait_steps(c);
        check("shrink_latency", 32'(c), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_led", 32'(led), 32'h01);
        check("async_rst_running", 32'(running), 32'd0);
        check("async_rst_step", 32'(step), 32'd0);
        tick_n(1);
        rst = 1'b0;
        tick_n(5);
        check("post_rst_idle", 32'(running), 32'd0);
        check("post_rst_led", 32'(led), 32'h01);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
